// File: rtl/skin_pkg.sv
`default_nettype none
// ============================================================================
// skin_pkg
// Shared types and constants for the centroid marker overlay.
// Revision: 1.0
// ============================================================================
package skin_pkg;

    localparam int COORD_W = 10;

    localparam logic [23:0] COL_STILL = 24'h00FF00;
    localparam logic [23:0] COL_MOVE  = 24'hFF0000;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        STILL  = 2'd1,
        MOVING = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/centroid_ema.sv
`default_nettype none
// ============================================================================
// centroid_ema
// One axis of the smoothed centroid: s <= s + ((in - s) >>> 2), plus |in - s|.
// Revision: 1.0
// ============================================================================
module centroid_ema
    import skin_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_update,
    input  logic [COORD_W-1:0] i_coord,
    output logic [COORD_W-1:0] o_s,
    output logic [COORD_W:0]   o_abs_d
);

    logic        [COORD_W-1:0] r_s;
    logic signed [COORD_W:0]   w_d;
    logic signed [COORD_W:0]   w_step;
    logic signed [COORD_W:0]   w_next;

    assign w_d     = $signed({1'b0, i_coord}) - $signed({1'b0, r_s});
    assign w_step  = w_d >>> 2;
    // Result always lies between s and in, so it is non-negative and fits.
    assign w_next  = $signed({1'b0, r_s}) + w_step;
    assign o_abs_d = w_d[COORD_W] ? $unsigned(-w_d) : $unsigned(w_d);
    assign o_s     = r_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s <= '0;
        end else if (i_load) begin
            r_s <= i_coord;
        end else if (i_update) begin
            r_s <= COORD_W'(w_next);
        end
    end

endmodule
`default_nettype wire

// File: rtl/centroid_marker.sv
`default_nettype none
// ============================================================================
// centroid_marker
// Smooths the per-frame centroid, tracks motion state and draws a crosshair.
// Revision: 1.0
// ============================================================================
module centroid_marker
    import skin_pkg::*;
#(
    parameter int IMG_W        = 720,
    parameter int IMG_H        = 576,
    parameter int ARM_LEN      = 8,
    parameter int MOVE_THR     = 4,
    parameter int STILL_FRAMES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               de,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [23:0]        pix_in,
    input  logic [COORD_W-1:0] c_w,
    input  logic [COORD_W-1:0] c_h,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    output logic               de_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic [23:0]        pix_o,
    output logic [COORD_W-1:0] x_s,
    output logic [COORD_W-1:0] y_s,
    output logic               moving,
    output logic               target_ok
);

    localparam int                 QW          = (STILL_FRAMES < 1) ? 1 : $clog2(STILL_FRAMES + 1);
    localparam logic [QW-1:0]      C_QUIET_MAX = QW'(STILL_FRAMES);
    localparam logic [COORD_W+1:0] C_MOVE_THR  = (COORD_W + 2)'(MOVE_THR);
    localparam logic [COORD_W:0]   C_ARM       = (COORD_W + 1)'(ARM_LEN);
    localparam logic [COORD_W:0]   C_IMG_W     = (COORD_W + 1)'(IMG_W);
    localparam logic [COORD_W:0]   C_IMG_H     = (COORD_W + 1)'(IMG_H);

    state_t             r_state;
    logic [QW-1:0]      r_quiet;
    logic               r_moving;
    logic               r_target_ok;
    logic               r_vsync_q;
    logic               r_de;
    logic               r_hsync;
    logic [23:0]        r_pix;

    logic               w_sof, w_valid, w_frame, w_upd, w_load, w_step, w_fast;
    logic [COORD_W:0]   w_abs_dx, w_abs_dy;
    logic [COORD_W+1:0] w_m;
    logic [QW-1:0]      w_quiet_inc;
    logic signed [COORD_W:0] w_dcol, w_drow;
    logic [COORD_W:0]   w_adcol, w_adrow;
    logic               w_mark, w_show;

    // vsync_q only advances with ce, so a masked sof is seen again later.
    assign w_sof   = vsync & ~r_vsync_q;
    assign w_valid = ({1'b0, x_in} < C_IMG_W) && ({1'b0, y_in} < C_IMG_H);
    assign w_frame = ce & w_sof;
    assign w_upd   = w_frame & w_valid;
    assign w_load  = w_upd & (r_state == INIT);
    assign w_step  = w_upd & (r_state != INIT);

    centroid_ema u_ema_x (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_update (w_step),
        .i_coord  (x_in),
        .o_s      (x_s),
        .o_abs_d  (w_abs_dx)
    );

    centroid_ema u_ema_y (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_update (w_step),
        .i_coord  (y_in),
        .o_s      (y_s),
        .o_abs_d  (w_abs_dy)
    );

    assign w_m         = {1'b0, w_abs_dx} + {1'b0, w_abs_dy};
    assign w_fast      = w_m > C_MOVE_THR;
    assign w_quiet_inc = (r_quiet == C_QUIET_MAX) ? r_quiet : r_quiet + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= INIT;
            r_quiet     <= '0;
            r_moving    <= 1'b0;
            r_target_ok <= 1'b0;
        end else if (w_frame) begin
            r_target_ok <= w_valid;
            if (w_valid) begin
                case (r_state)
                    INIT: begin
                        r_state  <= STILL;
                        r_moving <= 1'b0;
                        r_quiet  <= '0;
                    end
                    STILL: begin
                        if (w_fast) begin
                            r_state  <= MOVING;
                            r_moving <= 1'b1;
                            r_quiet  <= '0;
                        end
                    end
                    MOVING: begin
                        if (w_fast) begin
                            r_quiet <= '0;
                        end else begin
                            r_quiet <= w_quiet_inc;
                            if (w_quiet_inc == C_QUIET_MAX) begin
                                r_state  <= STILL;
                                r_moving <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state  <= INIT;
                        r_moving <= 1'b0;
                        r_quiet  <= '0;
                    end
                endcase
            end
        end
    end

    // 11-bit signed distances so arms near an edge clip instead of wrapping.
    assign w_dcol  = $signed({1'b0, c_w}) - $signed({1'b0, x_s});
    assign w_drow  = $signed({1'b0, c_h}) - $signed({1'b0, y_s});
    assign w_adcol = w_dcol[COORD_W] ? $unsigned(-w_dcol) : $unsigned(w_dcol);
    assign w_adrow = w_drow[COORD_W] ? $unsigned(-w_drow) : $unsigned(w_drow);
    assign w_mark  = ((w_dcol == '0) && (w_adrow <= C_ARM)) ||
                     ((w_drow == '0) && (w_adcol <= C_ARM));
    assign w_show  = de & r_target_ok & (r_state != INIT) & w_mark;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vsync_q <= 1'b0;
            r_de      <= 1'b0;
            r_hsync   <= 1'b0;
            r_pix     <= '0;
        end else if (ce) begin
            r_vsync_q <= vsync;
            r_de      <= de;
            r_hsync   <= hsync;
            r_pix     <= w_show ? (r_moving ? COL_MOVE : COL_STILL) : pix_in;
        end
    end

    assign de_o      = r_de;
    assign hsync_o   = r_hsync;
    assign vsync_o   = r_vsync_q;
    assign pix_o     = r_pix;
    assign moving    = r_moving;
    assign target_ok = r_target_ok;

endmodule
`default_nettype wire

// File: tb/tb_centroid_marker.sv
`default_nettype none
// ============================================================================
// tb_centroid_marker
// Directed, table-driven bench for centroid_marker.
// Revision: 1.0
// ============================================================================
module tb_centroid_marker;

    logic        clk = 1'b0;
    logic        rst, ce, de, hsync, vsync;
    logic [23:0] pix_in;
    logic [9:0]  c_w, c_h, x_in, y_in;
    logic        de_o, hsync_o, vsync_o, moving, target_ok;
    logic [23:0] pix_o;
    logic [9:0]  x_s, y_s;

    int n_vec = 0;
    int n_bad = 0;

    centroid_marker dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .de        (de),
        .hsync     (hsync),
        .vsync     (vsync),
        .pix_in    (pix_in),
        .c_w       (c_w),
        .c_h       (c_h),
        .x_in      (x_in),
        .y_in      (y_in),
        .de_o      (de_o),
        .hsync_o   (hsync_o),
        .vsync_o   (vsync_o),
        .pix_o     (pix_o),
        .x_s       (x_s),
        .y_s       (y_s),
        .moving    (moving),
        .target_ok (target_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  x, y;
        logic [9:0]  ex, ey;
        logic        emv, etok;
        logic [9:0]  pc, pr;
        logic [23:0] pin, epix;
    } vec_t;

    vec_t tbl [7];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_sof(input logic [9:0] x, input logic [9:0] y);
        de    = 1'b0;
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        x_in  = x;
        y_in  = y;
        tick();
    endtask

    task automatic pulse_reset;
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //         x    y    ex   ey  mv tok  pc   pr   pin         epix
        tbl[0] = '{100, 50, 100, 50, 0, 1, 100,  50, 24'h111111, 24'h00FF00};
        tbl[1] = '{120, 50, 105, 50, 1, 1, 105,  58, 24'h121212, 24'hFF0000};
        tbl[2] = '{106, 50, 105, 50, 1, 1, 105,  59, 24'h222222, 24'h222222};
        tbl[3] = '{106, 50, 105, 50, 1, 1,  97,  50, 24'h232323, 24'hFF0000};
        tbl[4] = '{106, 50, 105, 50, 0, 1, 113,  50, 24'h242424, 24'h00FF00};
        tbl[5] = '{1023, 1023, 105, 50, 0, 0, 105, 50, 24'h333333, 24'h333333};
        tbl[6] = '{106, 50, 105, 50, 0, 1, 104,  51, 24'h444444, 24'h444444};

        rst = 1'b0; ce = 1'b1; de = 1'b0; hsync = 1'b0; vsync = 1'b0;
        pix_in = '0; c_w = '0; c_h = '0; x_in = '0; y_in = '0;
        tick();
        tick();
        chk("reset_pix_o", pix_o, 0);
        chk("reset_x_s", x_s, 0);
        chk("reset_y_s", y_s, 0);
        chk("reset_moving", moving, 0);
        chk("reset_target_ok", target_ok, 0);
        chk("reset_timing", {de_o, hsync_o, vsync_o}, 0);
        rst = 1'b1;

        // Frame sequence: INIT load, motion, three quiet frames, invalid, valid.
        for (int i = 0; i < 7; i++) begin
            do_sof(tbl[i].x, tbl[i].y);
            chk($sformatf("frame%0d_x_s", i), x_s, tbl[i].ex);
            chk($sformatf("frame%0d_y_s", i), y_s, tbl[i].ey);
            chk($sformatf("frame%0d_moving", i), moving, tbl[i].emv);
            chk($sformatf("frame%0d_target_ok", i), target_ok, tbl[i].etok);
            de = 1'b1; hsync = 1'b1;
            c_w = tbl[i].pc; c_h = tbl[i].pr; pix_in = tbl[i].pin;
            tick();
            chk($sformatf("frame%0d_pix_o", i), pix_o, tbl[i].epix);
            chk($sformatf("frame%0d_de_hs", i), {de_o, hsync_o}, 2'b11);
            de = 1'b0; hsync = 1'b0;
        end

        // Corner placement: arms clip at the image edge without wrapping.
        pulse_reset();
        do_sof(10'd3, 10'd3);
        chk("corner_x_s", x_s, 3);
        chk("corner_y_s", y_s, 3);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                de = 1'b1; c_w = 10'(c); c_h = 10'(r); pix_in = 24'hABCDEF;
                tick();
                chk($sformatf("corner_pix(%0d,%0d)", c, r), pix_o,
                    ((c == 3 && r <= 11) || (r == 3 && c <= 11)) ? 24'h00FF00 : 24'hABCDEF);
            end
        end
        for (int k = 1015; k < 1024; k++) begin
            de = 1'b1; c_w = 10'(k); c_h = 10'd3; pix_in = 24'h0F0F0F;
            tick();
            chk($sformatf("nowrap_col%0d", k), pix_o, 24'h0F0F0F);
            c_w = 10'd3; c_h = 10'(k);
            tick();
            chk($sformatf("nowrap_row%0d", k), pix_o, 24'h0F0F0F);
        end
        de = 1'b0;

        // Clock enable low across the vsync rise: exactly one late update.
        vsync = 1'b0;
        tick();
        ce = 1'b0; vsync = 1'b1; x_in = 10'd10; y_in = 10'd3;
        tick(); tick(); tick();
        chk("ce_hold_x_s", x_s, 3);
        chk("ce_hold_moving", moving, 0);
        ce = 1'b1;
        tick();
        chk("ce_update_x_s", x_s, 4);
        chk("ce_update_moving", moving, 1);
        tick(); tick();
        chk("ce_single_x_s", x_s, 4);

        // Asynchronous reset mid-line while moving.
        de = 1'b1; hsync = 1'b1; c_w = 10'd4; c_h = 10'd3; pix_in = 24'h000001;
        tick();
        chk("pre_rst_pix_o", pix_o, 24'hFF0000);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_pix_o", pix_o, 0);
        chk("async_rst_timing", {de_o, hsync_o, vsync_o}, 0);
        chk("async_rst_moving", moving, 0);
        chk("async_rst_x_s", x_s, 0);
        chk("async_rst_target_ok", target_ok, 0);
        #1;
        rst = 1'b1; de = 1'b0; hsync = 1'b0;
        do_sof(10'd200, 10'd100);
        chk("post_rst_x_s", x_s, 200);
        chk("post_rst_y_s", y_s, 100);
        chk("post_rst_moving", moving, 0);
        chk("post_rst_target_ok", target_ok, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
